mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning bus data/address width.
REQ-002 SHALL have parameter STARVE_MAX, default 4, meaning consecutive lost contended grants after which fetch wins.
REQ-003 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port if_req  input  1  fetch request, held until if_ack.
REQ-006 SHALL have port if_addr  input  XLEN  fetch byte address.
REQ-007 SHALL have port if_rdata  output  XLEN  fetched word.
REQ-008 SHALL have port if_ack  output  1  one-cycle fetch completion pulse.
REQ-009 SHALL have port d_req  input  1  data request, held until d_ack.
REQ-010 SHALL have port d_we  input  1  1=store, 0=load.
REQ-011 SHALL have ports d_addr  input  XLEN, d_wdata  input  XLEN, d_sel_byte  input  4  data address, store data, byte lanes.
REQ-012 SHALL have ports d_rdata  output  XLEN, d_ack  output  1  load data, one-cycle completion pulse.
REQ-013 SHALL have ports m_req  output  1, m_we  output  1, m_addr  output  XLEN-2 (word address), m_wdata  output  XLEN, m_sel_byte  output  4  single-port memory command.
REQ-014 SHALL have ports m_rdata  input  XLEN, m_ack  input  1  memory response; m_ack arrives 1 or more cycles after m_req.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-016 IDLE: if_req or d_req sampled -> latch winner, its address/data/we/sel_byte into command registers -> ISSUE; none -> stay IDLE.
REQ-017 Requests SHALL be sampled only in IDLE; requests in other states wait.
REQ-018 Arbitration: only one requester -> it wins; both -> data wins unless starve_cnt == STARVE_MAX, then fetch wins.
REQ-019 starve_cnt: +1 when both request and data wins, saturating at STARVE_MAX; cleared to 0 on any fetch grant; unchanged otherwise.
REQ-020 Fetch grants SHALL force m_we=0 and m_sel_byte=4'b1111.
REQ-021 m_addr SHALL equal latched address bits [XLEN-1:2]; bits [1:0] discarded.
REQ-022 ISSUE: m_req=1 for exactly one cycle with latched command -> WAIT.
REQ-023 WAIT: m_req=0; command outputs held; on m_ack=1 capture m_rdata into the winner's rdata register -> RESP.
REQ-024 m_ack in IDLE, ISSUE or RESP SHALL be ignored.
REQ-025 RESP: assert winner's ack (if_ack or d_ack) for one cycle -> IDLE; never both acks in the same cycle.
REQ-026 Store completions SHALL also be acknowledged via d_ack; d_rdata holds m_rdata as captured (no meaning).
REQ-027 if_rdata and d_rdata SHALL hold last captured value until next capture for the same requester.
REQ-028 With 1-cycle memory: req asserted in cycle 0 while IDLE -> m_req cycle 1 -> m_ack cycle 2 -> ack cycle 3; back-to-back issue rate one transaction per 4 cycles.
REQ-029 A requester dropping req before ack SHALL not abort the in-flight transaction; ack still issued.

Reset
REQ-030 rst_n=0 at posedge SHALL force state IDLE, starve_cnt 0, m_req 0, m_we 0, m_addr 0, m_wdata 0, m_sel_byte 0, if_ack 0, d_ack 0, if_rdata 0, d_rdata 0.
REQ-031 Reset mid-transaction SHALL drop it without ack; a later stale m_ack SHALL be ignored per REQ-024.

Verification
REQ-032 Lone fetch: if_req=1, if_addr=0x0000_0010, memory returns 0x0000_0013 -> m_req cycle 1 with m_addr=0x4, m_we=0, m_sel_byte=4'b1111; if_ack cycle 3, if_rdata=0x0000_0013.
REQ-033 Lone store: d_req=1, d_we=1, d_addr=0x0000_0104, d_wdata=0xDEAD_BEEF, d_sel_byte=4'b0011 -> m_addr=0x41, m_we=1, m_wdata=0xDEAD_BEEF, m_sel_byte=4'b0011; d_ack cycle 3, if_ack stays 0.
REQ-034 Contention: if_req and d_req both held continuously, requesters re-request immediately after ack, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-035 Slow memory: m_ack delayed 5 cycles after m_req -> m_req high exactly one cycle, outputs stable through WAIT, ack 1 cycle after m_ack.
REQ-036 Reset in WAIT: rst_n=0 one cycle, then m_ack=1 -> no if_ack/d_ack, state IDLE, all outputs 0.
REQ-037 Spurious m_ack in IDLE with no requests -> no ack, rdata registers unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one single-port memory.
// Data normally wins contention; fetch wins after STARVE_MAX consecutive contended losses.
//
// state | meaning
// IDLE  | sample requests, latch winner's command
// ISSUE | m_req high for one cycle
// WAIT  | hold command, wait for m_ack, capture m_rdata
// RESP  | one-cycle ack to the winner
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_ack,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [3:0]      d_sel_byte,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_ack,
  output logic            m_req,
  output logic            m_we,
  output logic [XLEN-3:0] m_addr,
  output logic [XLEN-1:0] m_wdata,
  output logic [3:0]      m_sel_byte,
  input  logic [XLEN-1:0] m_rdata,
  input  logic            m_ack
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int SW = $clog2(STARVE_MAX + 2);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  state_t          state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            gnt_d_q, gnt_d_d;
  logic            we_q, we_d;
  logic [XLEN-3:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      sel_q, sel_d;
  logic [XLEN-1:0] if_rdata_q, if_rdata_d;
  logic [XLEN-1:0] d_rdata_q, d_rdata_d;
  logic            data_wins;

  // Byte-offset bits have no meaning on a word-addressed memory.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      gnt_d_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= 4'b0000;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      gnt_d_q    <= gnt_d_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    gnt_d_d    = gnt_d_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sel_d      = sel_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    data_wins  = d_req && !(if_req && (starve_q == STARVE_TOP));

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          state_d = ISSUE;
          if (data_wins) begin
            gnt_d_d = 1'b1;
            we_d    = d_we;
            addr_d  = d_addr[XLEN-1:2];
            wdata_d = d_wdata;
            sel_d   = d_sel_byte;
            // data only wins contention below the limit, so this never overflows
            if (if_req) starve_d = starve_q + SW'(1);
          end else begin
            gnt_d_d  = 1'b0;
            we_d     = 1'b0;
            addr_d   = if_addr[XLEN-1:2];
            wdata_d  = '0;
            sel_d    = 4'b1111;
            starve_d = '0;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (m_ack) begin
          state_d = RESP;
          if (gnt_d_q) d_rdata_d  = m_rdata;
          else         if_rdata_d = m_rdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign m_req      = (state_q == ISSUE);
  assign m_we       = we_q;
  assign m_addr     = addr_q;
  assign m_wdata    = wdata_q;
  assign m_sel_byte = sel_q;
  assign if_ack     = (state_q == RESP) && !gnt_d_q;
  assign d_ack      = (state_q == RESP) && gnt_d_q;
  assign if_rdata   = if_rdata_q;
  assign d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic checked every cycle
// against a transaction-timestamp model of the arbiter.
module tb_mem_port_arbiter;
  localparam int XLEN = 32;
  localparam int SMAX = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            if_req, d_req, d_we, m_ack;
  logic [XLEN-1:0] if_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]      d_sel_byte;
  logic [XLEN-1:0] if_rdata, d_rdata, m_wdata;
  logic            if_ack, d_ack, m_req, m_we;
  logic [XLEN-3:0] m_addr;
  logic [3:0]      m_sel_byte;

  mem_port_arbiter #(.XLEN(XLEN), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_sel_byte(d_sel_byte), .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_sel_byte(m_sel_byte), .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: one transaction record with cycle stamps
  int              cyc = 0;
  bit              model_on = 0;
  bit              busy = 0;
  bit              win_d = 0;
  int              issue_cyc = 0;
  int              resp_cyc = -1;
  int              starve = 0;
  logic            l_we = 0;
  logic [XLEN-3:0] l_addr = '0;
  logic [XLEN-1:0] l_wd = '0;
  logic [3:0]      l_sel = '0;
  bit              wd_known = 1;
  logic [XLEN-1:0] e_ifr = '0, e_dr = '0;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      model_on = 1; busy = 0; starve = 0; resp_cyc = -1;
      l_we = 0; l_addr = '0; l_wd = '0; l_sel = '0; wd_known = 1;
      e_ifr = '0; e_dr = '0;
    end else if (model_on) begin
      if (!busy) begin
        if (if_req || d_req) begin
          win_d = d_req && !(if_req && starve == SMAX);
          if (win_d) begin
            if (if_req) starve = (starve == SMAX) ? SMAX : starve + 1;
            l_we = d_we; l_addr = d_addr[XLEN-1:2]; l_wd = d_wdata; l_sel = d_sel_byte;
            wd_known = 1;
          end else begin
            starve = 0;
            l_we = 0; l_addr = if_addr[XLEN-1:2]; l_sel = 4'hF; wd_known = 0;
          end
          busy = 1; issue_cyc = cyc + 1; resp_cyc = -1;
        end
      end else if (resp_cyc < 0) begin
        if (cyc > issue_cyc && m_ack) begin
          if (win_d) e_dr = m_rdata; else e_ifr = m_rdata;
          resp_cyc = cyc + 1;
        end
      end else if (cyc == resp_cyc) begin
        busy = 0;
      end
    end
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (model_on) begin
      chk("m_req", m_req, busy && cyc == issue_cyc);
      chk("if_ack", if_ack, busy && cyc == resp_cyc && !win_d);
      chk("d_ack", d_ack, busy && cyc == resp_cyc && win_d);
      chk("m_we", m_we, l_we);
      chk("m_addr", m_addr, l_addr);
      chk("m_sel_byte", m_sel_byte, l_sel);
      if (wd_known) chk("m_wdata", m_wdata, l_wd);
      chk("if_rdata", if_rdata, e_ifr);
      chk("d_rdata", d_rdata, e_dr);
    end
  end

  // ---------------- stimulus: memory responder and random requesters advance on each tick
  int mem_mode = 0;   // 0 manual, 1 fixed delay, 2 random delay plus spurious acks
  int mem_dly  = 1;
  int mcnt     = 0;
  bit rand_mode = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_mode != 0) begin
      if (m_req) begin
        mcnt  = (mem_mode == 2) ? int'($urandom_range(1, 6)) : mem_dly;
        m_ack = 1'b0;
      end else if (mcnt > 0) begin
        mcnt--;
        m_ack = (mcnt == 0);
        m_rdata = $urandom;
      end else begin
        m_ack = (mem_mode == 2) && ($urandom % 8 == 0);
        m_rdata = $urandom;
      end
    end
    if (rand_mode) begin
      if (if_req) begin
        if (if_ack) if_req = $urandom % 2;
        else if ($urandom % 64 == 0) if_req = 1'b0;
      end else begin
        if_addr = $urandom;
        if_req  = ($urandom % 3 == 0);
      end
      if (d_req) begin
        if (d_ack) d_req = $urandom % 2;
        else if ($urandom % 64 == 0) d_req = 1'b0;
      end else begin
        d_addr = $urandom; d_wdata = $urandom; d_we = $urandom % 2;
        d_sel_byte = 4'($urandom);
        d_req = ($urandom % 3 == 0);
      end
      rst_n = ($urandom % 150 != 0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_req"}, m_req, 0);
    chk({tag, "_m_we"}, m_we, 0);
    chk({tag, "_m_addr"}, m_addr, 0);
    chk({tag, "_m_wdata"}, m_wdata, 0);
    chk({tag, "_m_sel"}, m_sel_byte, 0);
    chk({tag, "_if_ack"}, if_ack, 0);
    chk({tag, "_d_ack"}, d_ack, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  logic exp_g [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int mreq_cnt, ack_cnt, ack_at, last_g, waited;
    bit got;
    rst_n = 0; if_req = 0; d_req = 0; d_we = 0; m_ack = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_sel_byte = '0; m_rdata = '0;
    tick(); tick();
    rst_n = 1;
    chk_all_zero("reset");
    tick();

    // lone fetch
    if_req = 1; if_addr = 32'h0000_0010;
    tick();
    chk("fetch_m_req", m_req, 1);
    chk("fetch_m_addr", m_addr, 30'h4);
    chk("fetch_m_we", m_we, 0);
    chk("fetch_m_sel", m_sel_byte, 4'hF);
    tick();
    chk("fetch_wait_m_req", m_req, 0);
    m_ack = 1; m_rdata = 32'h0000_0013;
    tick();
    m_ack = 0;
    chk("fetch_if_ack", if_ack, 1);
    chk("fetch_d_ack", d_ack, 0);
    chk("fetch_if_rdata", if_rdata, 32'h13);
    if_req = 0;
    tick();
    chk("fetch_ack_pulse", if_ack, 0);

    // lone store
    d_req = 1; d_we = 1; d_addr = 32'h0000_0104; d_wdata = 32'hDEAD_BEEF; d_sel_byte = 4'b0011;
    tick();
    chk("store_m_req", m_req, 1);
    chk("store_m_addr", m_addr, 30'h41);
    chk("store_m_we", m_we, 1);
    chk("store_m_wdata", m_wdata, 32'hDEAD_BEEF);
    chk("store_m_sel", m_sel_byte, 4'b0011);
    tick();
    m_ack = 1; m_rdata = 32'h0BAD_F00D;
    tick();
    m_ack = 0;
    chk("store_d_ack", d_ack, 1);
    chk("store_if_ack", if_ack, 0);
    chk("store_d_rdata", d_rdata, 32'h0BAD_F00D);
    chk("store_if_rdata_kept", if_rdata, 32'h13);
    d_req = 0; d_we = 0;
    tick();

    // spurious m_ack while idle
    m_ack = 1; m_rdata = 32'hFFFF_FFFF;
    repeat (3) begin
      tick();
      chk("spur_if_ack", if_ack, 0);
      chk("spur_d_ack", d_ack, 0);
      chk("spur_m_req", m_req, 0);
      chk("spur_if_rdata", if_rdata, 32'h13);
      chk("spur_d_rdata", d_rdata, 32'h0BAD_F00D);
    end
    m_ack = 0;
    tick();

    // slow memory: ack 5 cycles after m_req
    mem_mode = 1; mem_dly = 5;
    d_req = 1; d_we = 0; d_addr = 32'h0000_0200; d_sel_byte = 4'hC;
    mreq_cnt = 0; ack_cnt = 0; ack_at = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (m_req) mreq_cnt++;
      if (d_ack) begin ack_cnt++; ack_at = i; d_req = 0; end
      if (i >= 2 && i <= 6) begin
        chk("slow_wait_m_addr", m_addr, 30'h80);
        chk("slow_wait_m_sel", m_sel_byte, 4'hC);
      end
    end
    chk("slow_m_req_cycles", mreq_cnt, 1);
    chk("slow_ack_count", ack_cnt, 1);
    chk("slow_ack_cycle", ack_at, 7);
    mem_mode = 0; m_ack = 0;
    tick();

    // reset while in WAIT, stale m_ack afterwards
    if_req = 1; if_addr = 32'h0000_0040;
    tick();
    tick();
    rst_n = 0;
    tick();
    rst_n = 1; if_req = 0; m_ack = 1; m_rdata = 32'h1234_5678;
    chk_all_zero("rstwait");
    tick();
    m_ack = 0;
    chk("rstwait_stale_if_ack", if_ack, 0);
    chk("rstwait_stale_d_ack", d_ack, 0);
    chk("rstwait_stale_m_req", m_req, 0);
    chk("rstwait_stale_if_rdata", if_rdata, 0);
    tick();
    chk("rstwait_late_if_ack", if_ack, 0);

    // contention with both requesters held
    mem_mode = 1; mem_dly = 1;
    if_req = 1; if_addr = 32'h0000_0800; d_req = 1; d_we = 0; d_addr = 32'h0000_0900;
    last_g = -1;
    for (int g = 0; g < 10; g++) begin
      waited = 0; got = 0;
      do begin tick(); waited++; end while (!(if_ack || d_ack) && waited < 12);
      if (!(if_ack || d_ack)) chk("grant_timeout", 0, 1);
      got = d_ack;
      chk("grant_order", got, exp_g[g]);
      if (last_g >= 0) chk("grant_spacing", cyc - last_g, 4);
      last_g = cyc;
    end
    if_req = 0; d_req = 0;
    repeat (4) tick();

    // randomized traffic
    mem_mode = 2; rand_mode = 1;
    repeat (3000) tick();
    rand_mode = 0; mem_mode = 0;
    if_req = 0; d_req = 0; m_ack = 0; rst_n = 1;
    repeat (12) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
